// File: rtl/nios1_pio_pkg.sv
// rtl/nios1_pio_pkg.sv - shared register map and address type for the LED output PIO
package nios1_pio_pkg;

   typedef logic [1:0] pio_addr_t;

   localparam pio_addr_t ADDR_DATA  = 2'd0;
   localparam pio_addr_t ADDR_SET   = 2'd1;
   localparam pio_addr_t ADDR_CLR   = 2'd2;
   localparam pio_addr_t ADDR_BLINK = 2'd3;

endpackage

// File: rtl/nios1_blink_prescaler.sv
// rtl/nios1_blink_prescaler.sv - blink half-period counter and phase flop (used when NIOS1_PIO_LED_BLINK_EN is defined)
module nios1_blink_prescaler #(
   parameter int DIV = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic phase,
   output logic wrap
);

   localparam int CW = $clog2(DIV + 1);

   logic [CW-1:0] count;

   // Terminal count; the top uses it to build the next phase value for out_port.
   assign wrap = (count == CW'(DIV - 1));

   // Count 0..DIV-1 and toggle phase on wrap; a clear beats the wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         phase <= 1'b0;
      end else if (clear) begin
         count <= '0;
         phase <= 1'b0;
      end else if (wrap) begin
         count <= '0;
         phase <= ~phase;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/nios1_pio_led.sv
// rtl/nios1_pio_led.sv - Avalon-MM LED output PIO with set/clear and optional blink (NIOS1_PIO_LED_BLINK_EN)
module nios1_pio_led
   import nios1_pio_pkg::*;
#(
   parameter int          WIDTH       = 18,
   parameter logic [31:0] RESET_VALUE = 32'd0,
   parameter int          BLINK_DIV   = 25000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

   pio_addr_t        addr;
   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] data_next;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] mask_next;
   logic             phase_next;
   logic             unused_wd_bits;

   assign addr           = address;
   assign wr             = chipselect & ~write_n;
   assign wd             = writedata[WIDTH-1:0];
   assign unused_wd_bits = ^writedata;

   // Next data value from the write decode; SET/CLEAR are read-modify-write in one cycle.
   always_comb begin
      data_next = data_reg;
      if (wr) begin
         case (addr)
            ADDR_DATA: data_next = wd;
            ADDR_SET:  data_next = data_reg | wd;
            ADDR_CLR:  data_next = data_reg & ~wd;
            default:   data_next = data_reg;
         endcase
      end
   end

`ifdef NIOS1_PIO_LED_BLINK_EN
   logic blink_wr;
   logic phase;
   logic wrap;

   assign blink_wr   = wr && (addr == ADDR_BLINK);
   assign mask_next  = blink_wr ? wd : mask_reg;
   // A blink write restarts the pattern in phase 0, even on the wrap cycle.
   assign phase_next = ~blink_wr & (phase ^ wrap);

   // Blink mask register.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_reg <= '0;
      end else begin
         mask_reg <= mask_next;
      end
   end

   nios1_blink_prescaler #(
      .DIV (BLINK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (blink_wr),
      .phase (phase),
      .wrap  (wrap)
   );
`else
   assign mask_reg   = '0;
   assign mask_next  = '0;
   assign phase_next = 1'b0;
`endif

   // Data register, and LED drive built from next-state values so a write shows on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg <= RST_VAL;
         out_port <= RST_VAL;
      end else begin
         data_reg <= data_next;
         out_port <= data_next ^ (mask_next & {WIDTH{phase_next}});
      end
   end

   // Read mux registered every edge from current (pre-write) register values.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= 32'd0;
      end else begin
         case (addr)
            ADDR_DATA:  readdata <= 32'(data_reg);
            ADDR_BLINK: readdata <= 32'(mask_reg);
            default:    readdata <= 32'd0;
         endcase
      end
   end

endmodule
